// File: rtl/clmul_ctrl.sv
// clmul_ctrl: Zbc execute-stage front end that sequences the two-cycle carry-less multiplier core
module clmul_ctrl #(
  parameter bit ZERO_BYPASS = 1'b1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             pipe_stall,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             mul_start,
  output logic             mul_stall,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_eoc,
  input  logic [64:0]      mul_res
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, BUSY = 2'd2, DONE = 2'd3;
  logic [1:0]       state_q, state_d, op_q;
  logic [31:0]      a_q, b_q, data_q, slice;
  logic [TAG_W-1:0] tag_q, rtag_q;
  logic             accept, bypass, unused_res;
  assign unused_res = mul_res[64];
  assign req_ready  = state_q == IDLE && !flush && !pipe_stall;
  assign accept     = req_valid && req_ready;
  assign bypass     = (ZERO_BYPASS && (req_a == '0 || req_b == '0)) || req_op == 2'b11;
  assign rsp_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign mul_start  = state_q == LAUNCH && !flush;
  assign mul_stall  = pipe_stall;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign rsp_data   = data_q;
  assign rsp_tag    = rtag_q;
  // pick the architectural 32-bit window of the 64-bit product for the latched op
  always_comb begin
    slice = op_q == 2'b00 ? mul_res[31:0] :
            op_q == 2'b01 ? mul_res[63:32] :
            op_q == 2'b10 ? mul_res[62:31] : '0;
  end
  // sequencing: flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (bypass ? DONE : LAUNCH) : IDLE;
      LAUNCH:  state_d = pipe_stall ? LAUNCH : BUSY;
      BUSY:    state_d = mul_eoc ? DONE : BUSY;
      default: state_d = rsp_ready ? IDLE : DONE;
    endcase
    if (flush) state_d = IDLE;
  end
  // state, request latches and the held response; eoc is captured even under stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        tag_q <= req_tag;
      end
      if (accept && bypass) begin
        data_q <= '0;
        rtag_q <= req_tag;
      end
      if (state_q == BUSY && mul_eoc && !flush) begin
        data_q <= slice;
        rtag_q <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_clmul_ctrl.sv
// tb_clmul_ctrl: scoreboard bench with a behavioural two-cycle core and a carry-less product model
module tb_clmul_ctrl;
  logic        clk = 0, resetn = 1, flush = 0, pipe_stall = 0, req_valid = 0, rsp_ready = 1;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        req_ready, rsp_valid, busy, mul_start, mul_stall;
  logic [31:0] rsp_data, mul_a, mul_b;
  logic [4:0]  rsp_tag;
  logic        mul_eoc;
  logic [64:0] mul_res;
  typedef struct {logic [31:0] d; logic [4:0] t;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, nstart = 0, nrsp = 0;

  clmul_ctrl #(.ZERO_BYPASS(1'b1), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .pipe_stall(pipe_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy), .mul_start(mul_start),
    .mul_stall(mul_stall), .mul_a(mul_a), .mul_b(mul_b), .mul_eoc(mul_eoc), .mul_res(mul_res)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p ^= {32'b0, a} << i;
    return p;
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = clmul64(a, b);
    return op == 2'd0 ? p[31:0] : op == 2'd1 ? p[63:32] : op == 2'd2 ? p[62:31] : 32'd0;
  endfunction

  // behavioural core: eoc=1 while idle, two unstalled cycles after an accepted start
  int cnt;
  logic [31:0] pa, pb;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 0; mul_eoc <= 1'b1; mul_res <= '0; pa <= '0; pb <= '0;
    end else if (mul_start && !mul_stall) begin
      cnt <= 2; mul_eoc <= 1'b0; pa <= mul_a; pb <= mul_b;
    end else if (cnt != 0 && !mul_stall) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mul_eoc <= 1'b1;
        mul_res <= {1'($urandom), clmul64(pa, pb)};
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // monitor: scoreboard pop/compare, accept push, flush/reset drop
  always @(negedge clk) begin
    if (!resetn) q.delete();
    else begin
      chk("mul_stall", mul_stall, pipe_stall);
      if (mul_start && !mul_stall) nstart++;
      if (flush) q.delete();
      else begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got data %0h tag %0h with nothing pending", rsp_data, rsp_tag);
          end else begin
            chk("rsp_data", rsp_data, q[0].d);
            chk("rsp_tag", rsp_tag, q[0].t);
            if (rsp_ready) begin
              void'(q.pop_front());
              nrsp++;
            end
          end
        end
        if (req_valid && req_ready) q.push_back('{model(req_op, req_a, req_b), req_tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int n = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = t;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready %0b after %0d cycles, required 1", req_ready, n);
    end
    step();
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int n, input bit rnd);
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (rnd) pipe_stall = $urandom_range(0, 3) == 0;
      step();
      n++;
    end
    pipe_stall = 0;
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid %0b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] t, input logic [31:0] gold, input int lat);
    int n, s0 = nstart;
    send(op, a, b, t);
    wait_rsp(n, 0);
    chk("latency", 64'(n), 64'(lat));
    chk("golden", rsp_data, gold);
    chk("starts", 64'(nstart - s0), lat == 0 ? 64'd0 : 64'd1);
    step();
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int n, s0, r0;
    #1 resetn = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    chk("req_ready_idle", req_ready, 1);
    run(2'd0, 32'h3, 32'h3, 5'd7, 32'h5, 4);
    run(2'd1, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000, 4);
    run(2'd2, 32'h80000000, 32'h80000000, 5'd10, 32'h80000000, 4);
    run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h55555555, 4);
    run(2'd0, 32'h0, 32'h1234, 5'd3, 32'h0, 0);
    run(2'd3, 32'h1234, 32'h5678, 5'd4, 32'h0, 0);
    // backpressure: result held stable and no accept while waiting
    rsp_ready = 0;
    send(2'd1, 32'hDEADBEEF, 32'h13579BDF, 5'd12);
    wait_rsp(n, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_idle", busy, 0);
    // stall held in LAUNCH
    s0 = nstart;
    send(2'd2, 32'hA5A5F00F, 32'h0F0F1234, 5'd21);
    pipe_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_start_held", mul_start, 1);
      step();
    end
    pipe_stall = 0;
    wait_rsp(n, 0);
    chk("stall_golden", rsp_data, model(2'd2, 32'hA5A5F00F, 32'h0F0F1234));
    chk("stall_starts", 64'(nstart - s0), 1);
    step();
    // flush in BUSY drops the op; next op completes
    r0 = nrsp;
    send(2'd0, 32'h7, 32'h9, 5'd1);
    step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    run(2'd0, 32'h5, 32'h3, 5'd2, 32'hF, 4);
    chk("flush_rsp_count", 64'(nrsp - r0), 1);
    // flush coincident with rsp_ready in DONE
    send(2'd1, 32'h11111111, 32'h22222222, 5'd5);
    wait_rsp(n, 0);
    flush = 1;
    step();
    flush = 0;
    chk("flush_done_valid", rsp_valid, 0);
    chk("flush_done_busy", busy, 0);
    // randomized traffic with stalls and backpressure
    r0 = nrsp;
    for (int k = 0; k < 40; k++) begin
      int j = 0;
      send(2'($urandom), ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom,
           ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, 5'($urandom));
      wait_rsp(n, 1);
      while (rsp_valid && j < 20) begin
        rsp_ready = 1'($urandom);
        step();
        j++;
      end
      rsp_ready = 1;
      if (rsp_valid) step();
    end
    chk("rand_rsp_count", 64'(nrsp - r0), 40);
    // asynchronous reset mid-BUSY
    send(2'd0, 32'h3, 32'h5, 5'd6);
    step();
    #3 resetn = 0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_rsp_tag", rsp_tag, 0);
    chk("arst_mul_start", mul_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mul_ab", {mul_a, mul_b}, 0);
    step();
    resetn = 1;
    chk("arst_req_ready", req_ready, 1);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
